// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter that owns a shared N-bit register; one grant per cycle.
// Optional owner lock (LOCK state, lock port) is enabled by defining SHARED_REG_LOCK_EN.
module shared_reg_arbiter #(
    parameter int N        = 64,
    parameter int REQ      = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REQ-1:0]           req,
    input  logic [REQ*N-1:0]         wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [REQ-1:0]           lock,
`endif
    output logic [REQ-1:0]           gnt,
    output logic [N-1:0]             q,
    output logic                     q_valid,
    output logic [$clog2(REQ)-1:0]   owner,
    output logic [15:0]              wr_cnt
);
    localparam int PW = $clog2(REQ);

    if (REQ < 2 || REQ > 16 || (REQ & (REQ - 1)) != 0 || LOCK_MAX < 1 || LOCK_MAX > 255)
    begin : g_param_check
        $error("shared_reg_arbiter: REQ must be a power of two in 2..16, LOCK_MAX in 1..255");
    end

`ifdef SHARED_REG_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
`else
    typedef enum logic {IDLE, GRANT} state_t;
`endif

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  win;
    logic [PW-1:0]  idx;
    logic           found;
    logic [REQ-1:0] elig;

    // The requester granted this cycle is masked so a late-dropping req cannot write twice.
    always_comb begin
        elig  = req & ~((state == IDLE) ? {REQ{1'b0}} : gnt);
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < REQ; k++) begin
            idx = ptr + PW'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef SHARED_REG_LOCK_EN
    // The grant that enters LOCK counts as the first locked grant, so the owner
    // gets exactly LOCK_MAX back-to-back writes.
    logic [7:0] lock_cnt;
    logic       hold;
    assign hold = (state == LOCK) && req[owner] && lock[owner] && (lock_cnt < 8'(LOCK_MAX));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            wr_cnt  <= '0;
            ptr     <= '0;
`ifdef SHARED_REG_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
`ifdef SHARED_REG_LOCK_EN
            if (hold) begin
                q        <= wdata[owner*N +: N];
                wr_cnt   <= wr_cnt + 16'd1;
                lock_cnt <= lock_cnt + 8'd1;
            end else
`endif
            if (found) begin
                gnt      <= '0;
                gnt[win] <= 1'b1;
                q        <= wdata[win*N +: N];
                q_valid  <= 1'b1;
                owner    <= win;
                ptr      <= win + 1'b1;
                wr_cnt   <= wr_cnt + 16'd1;
`ifdef SHARED_REG_LOCK_EN
                if (lock[win]) begin
                    state    <= LOCK;
                    lock_cnt <= 8'd1;
                end else begin
                    state <= GRANT;
                end
`else
                state <= GRANT;
`endif
            end else begin
                gnt   <= '0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (default build, N=64, REQ=4): reset,
// rotation, no-double-write, pointer fairness/wrap, idle hold and wr_cnt wrap.
module tb_shared_reg_arbiter;
    localparam int N   = 64;
    localparam int REQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [REQ-1:0]    req;
    logic [REQ*N-1:0]  wdata;
    logic [REQ-1:0]    gnt;
    logic [N-1:0]      q;
    logic              q_valid;
    logic [1:0]        owner;
    logic [15:0]       wr_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    shared_reg_arbiter #(.N(N), .REQ(REQ), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        wdata = '0;
        for (int i = 0; i < REQ; i++) wdata[i*N +: N] = 64'h1000 + 64'(i);

        #12;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_q", q, 64'h0);
        chk("rst_qv", 64'(q_valid), 64'h0);
        chk("rst_owner", 64'(owner), 64'h0);
        chk("rst_cnt", 64'(wr_cnt), 64'h0);

        @(posedge clk);
        #3 reset = 1'b1;
        req = 4'b1111;
        step();
        chk("pre_gnt", 64'(gnt), 64'h1);
        chk("pre_q", q, 64'h1000);
        chk("pre_cnt", 64'(wr_cnt), 64'h1);

        // asynchronous reset mid-cycle with requests still pending
        #2 reset = 1'b0;
        #1;
        chk("async_gnt", 64'(gnt), 64'h0);
        chk("async_q", q, 64'h0);
        chk("async_qv", 64'(q_valid), 64'h0);
        chk("async_cnt", 64'(wr_cnt), 64'h0);
        #2 reset = 1'b1;

        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rot_gnt%0d", k), 64'(gnt), 64'(1 << (k % 4)));
            chk($sformatf("rot_q%0d", k), q, 64'h1000 + 64'(k % 4));
        end
        chk("rot_cnt", 64'(wr_cnt), 64'd8);
        chk("rot_owner", 64'(owner), 64'd3);
        chk("rot_qv", 64'(q_valid), 64'h1);

        // requester 3 holds gnt now; 0 must come before 3 again
        req = 4'b1001;
        step();
        chk("fair_gnt0", 64'(gnt), 64'h1);
        step();
        chk("fair_gnt1", 64'(gnt), 64'h8);
        chk("fair_cnt", 64'(wr_cnt), 64'd10);

        req = 4'b0000;
        step();
        chk("idle_gnt", 64'(gnt), 64'h0);
        step();
        chk("idle_q", q, 64'h1003);
        chk("idle_cnt", 64'(wr_cnt), 64'd10);

        wdata[2*N +: N] = 64'hDEAD;
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ndw_gnt%0d", k), 64'(gnt), (k % 2 == 0) ? 64'h4 : 64'h0);
        end
        chk("ndw_cnt", 64'(wr_cnt), 64'd12);
        chk("ndw_q", q, 64'hDEAD);
        chk("ndw_owner", 64'(owner), 64'd2);

        // ptr is 3: grants go 3, then wrap to 0, then 1
        req = 4'b1111;
        step();
        chk("wrap_gnt0", 64'(gnt), 64'h8);
        step();
        chk("wrap_gnt1", 64'(gnt), 64'h1);
        step();
        chk("wrap_gnt2", 64'(gnt), 64'h2);
        chk("wrap_q", q, 64'h1001);
        chk("wrap_cnt", 64'(wr_cnt), 64'd15);
        req = 4'b0000;
        step();
        chk("wrap_idle", 64'(gnt), 64'h0);

        req = 4'b1111;
        repeat (65520) step();
        chk("cnt_max", 64'(wr_cnt), 64'hFFFF);
        step();
        chk("cnt_wrap", 64'(wr_cnt), 64'h0);
        chk("cnt_qv", 64'(q_valid), 64'h1);
        chk("cnt_gnt", 64'(gnt), 64'h4);
        chk("cnt_q", q, 64'hDEAD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
